// File: rtl/xrad_cmac_accum.sv
// Multi-channel signed complex multiply-accumulate with round/saturate on frame end.
// Optional conjugate-weight mode: define XRAD_CMAC_CONJ_EN to add the in_conj port.
module xrad_cmac_accum #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15,
    parameter int ACC_W  = 40,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_last,
`ifdef XRAD_CMAC_CONJ_EN
    input  logic              in_conj,
`endif
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_sat
);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACC_W:0]   wide_t;

    localparam acc_t  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam wide_t OUT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam wide_t OUT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam wide_t HALF    = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W-1);

    logic adv;
    logic in_range;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !acc_clr;
    assign in_range = (int'(in_ch) < NUM_CH);

    // ---------------- Stage 0: input register (keeps the multipliers off the input pins)
    logic                     s0_valid;
    logic signed [DATA_W-1:0] s0_re, s0_im, s0_wre, s0_wim;
    logic [CH_W-1:0]          s0_ch;
    logic                     s0_last;
`ifdef XRAD_CMAC_CONJ_EN
    logic                     s0_conj;
`endif

    // NOTE: only the valid bits need reset; payload registers are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s0_valid <= 1'b0;
        else if (acc_clr) s0_valid <= 1'b0;
        else if (adv)     s0_valid <= in_valid && in_ready && in_range;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s0_re   <= in_re;
            s0_im   <= in_im;
            s0_wre  <= w_re;
            s0_wim  <= w_im;
            s0_ch   <= in_ch;
            s0_last <= in_last;
`ifdef XRAD_CMAC_CONJ_EN
            s0_conj <= in_conj;
`endif
        end
    end

    // ---------------- Stage 1: full-precision complex product
    logic signed [2*DATA_W-1:0] m_rr, m_ii, m_ri, m_ir;
    acc_t                       p_re, p_im;

    assign m_rr = s0_re * s0_wre;
    assign m_ii = s0_im * s0_wim;
    assign m_ri = s0_re * s0_wim;
    assign m_ir = s0_im * s0_wre;

    function automatic acc_t sext(input logic signed [2*DATA_W-1:0] x);
        return {{(ACC_W-2*DATA_W){x[2*DATA_W-1]}}, x};
    endfunction

    always_comb begin
        p_re = sext(m_rr) - sext(m_ii);
        p_im = sext(m_ri) + sext(m_ir);
`ifdef XRAD_CMAC_CONJ_EN
        if (s0_conj) begin
            p_re = sext(m_rr) + sext(m_ii);
            p_im = sext(m_ir) - sext(m_ri);
        end
`else
`endif
    end

    logic            s1_valid;
    acc_t            s1_p_re, s1_p_im;
    logic [CH_W-1:0] s1_ch;
    logic            s1_last;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s1_valid <= 1'b0;
        else if (acc_clr) s1_valid <= 1'b0;
        else if (adv)     s1_valid <= s0_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_p_re <= p_re;
            s1_p_im <= p_im;
            s1_ch   <= s0_ch;
            s1_last <= s0_last;
        end
    end

    // ---------------- Stage 2: accumulate, the single read-modify-write point per channel
    acc_t acc_re [NUM_CH];
    acc_t acc_im [NUM_CH];
    logic ovf    [NUM_CH];

    wide_t             sum_re_w, sum_im_w;
    acc_t              sum_re, sum_im;
    logic              sat_re, sat_im;
    logic [DATA_W-1:0] rnd_re, rnd_im;
    logic              clip_re, clip_im;

    function automatic acc_t sat_acc(input wide_t x);
        if (x[ACC_W] != x[ACC_W-1]) return x[ACC_W] ? ACC_MIN : ACC_MAX;
        return x[ACC_W-1:0];
    endfunction

    function automatic void round_sat(input acc_t s, output logic [DATA_W-1:0] r,
                                      output logic clip);
        wide_t rnd, sh;
        rnd = {s[ACC_W-1], s} + HALF;
        sh  = rnd >>> FRAC_W;
        if (sh > OUT_MAX) begin
            r    = OUT_MAX[DATA_W-1:0];
            clip = 1'b1;
        end else if (sh < OUT_MIN) begin
            r    = OUT_MIN[DATA_W-1:0];
            clip = 1'b1;
        end else begin
            r    = sh[DATA_W-1:0];
            clip = 1'b0;
        end
    endfunction

    always_comb begin
        sum_re_w = {acc_re[s1_ch][ACC_W-1], acc_re[s1_ch]} + {s1_p_re[ACC_W-1], s1_p_re};
        sum_im_w = {acc_im[s1_ch][ACC_W-1], acc_im[s1_ch]} + {s1_p_im[ACC_W-1], s1_p_im};
        sat_re   = sum_re_w[ACC_W] ^ sum_re_w[ACC_W-1];
        sat_im   = sum_im_w[ACC_W] ^ sum_im_w[ACC_W-1];
        sum_re   = sat_acc(sum_re_w);
        sum_im   = sat_acc(sum_im_w);
        round_sat(sum_re, rnd_re, clip_re);
        round_sat(sum_im, rnd_im, clip_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_re[i] <= '0;
                acc_im[i] <= '0;
                ovf[i]    <= 1'b0;
            end
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (acc_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_re[i] <= '0;
                acc_im[i] <= '0;
                ovf[i]    <= 1'b0;
            end
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    acc_re[s1_ch] <= '0;
                    acc_im[s1_ch] <= '0;
                    ovf[s1_ch]    <= 1'b0;
                    out_re        <= rnd_re;
                    out_im        <= rnd_im;
                    out_ch        <= s1_ch;
                    out_sat       <= ovf[s1_ch] | sat_re | sat_im | clip_re | clip_im;
                end else begin
                    acc_re[s1_ch] <= sum_re;
                    acc_im[s1_ch] <= sum_im;
                    ovf[s1_ch]    <= ovf[s1_ch] | sat_re | sat_im;
                end
            end
        end
    end

endmodule

// File: doc/xrad_cmac_accum.md
# xrad_cmac_accum

Parametrised, multi-channel, signed complex multiply-accumulate engine for the XRAD datapath. It accepts a stream of complex samples and complex weights tagged with a channel index, and accumulates each channel's products in its own accumulator. On a frame's last beat it emits a rounded, saturated complex result. Fully pipelined with valid/ready handshakes on both sides; it sits between the XRAD sample router and the beamforming combiner.

## Interface
- `DATA_W`, 16: signed width of each sample/weight component and of each output component.
- `FRAC_W`, 15: fractional bits of the Q format; the output is the accumulator shifted right by `FRAC_W`.
- `ACC_W`, 40: signed accumulator width per component. Must satisfy `ACC_W >= 2*DATA_W+1`.
- `NUM_CH`, 4: number of independent accumulators (channels), ≥1.
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: the input beat is accepted when `in_valid && in_ready`.
- `in_re` / `in_im`, in, DATA_W each: sample, two's complement.
- `w_re` / `w_im`, in, DATA_W each: weight, two's complement.
- `in_ch`, in, CH_W: target channel. Values ≥ `NUM_CH` are ignored (see Operation).
- `in_last`, in, 1: final beat of this channel's frame.
- `acc_clr`, in, 1: synchronous clear of all accumulators and the pipeline.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result consumed when `out_valid && out_ready`.
- `out_re` / `out_im`, out, DATA_W each: rounded, saturated result.
- `out_ch`, out, CH_W: channel of the result.
- `out_sat`, out, 1: the output clipped or the accumulator saturated during this frame.

## Operation
- Pipeline stall condition is `adv = !out_valid || out_ready`. `in_ready = adv && !acc_clr`.
- S1 (product register): registered when `adv` is high.
  - `p_re = in_re*w_re - in_im*w_im`
  - `p_im = in_re*w_im + in_im*w_re`
  - Full precision, 2*DATA_W+1 bits, sign-extended to ACC_W.
  - Also registers `ch`, `last`, and a valid bit.
- S2 (accumulate): when `adv` is high and S1 is valid, compute `sum = acc[ch] + p`.
  - `sum` saturates to the ACC_W signed range per component.
  - On saturation, set sticky `ovf[ch]`.
- If `last` is clear: `acc[ch] <= sum`.
- If `last` is set:
  - Compute `r = (sum + 2^(FRAC_W-1)) >>> FRAC_W` (arithmetic shift), then saturate to DATA_W per component.
  - Load `out_re/out_im/out_ch`.
  - Drive `out_sat = ovf[ch] | clipped`.
  - Set `out_valid`.
  - Clear `acc[ch]` and `ovf[ch]` to 0.
- Rounding is round-half-up.
- Saturation limits are `+(2^(DATA_W-1)-1)` and `-2^(DATA_W-1)`.
- Same-channel back-to-back beats need no forwarding: S2 is the single read-modify-write point.
- Channels interleave freely. Each accumulator is independent.
- `in_ch >= NUM_CH`: the beat is accepted, but it updates no state and produces no output.
- `acc_clr` clears all `acc` and `ovf` registers, the S1 valid bit, and `out_valid`. It has priority over any same-cycle accumulate.

## Timing
- Reset values: `out_valid=0`, `out_re=0`, `out_im=0`, `out_ch=0`, `out_sat=0`. All accumulators, `ovf` and the S1 valid bit are also 0.
- `in_ready` goes to 1 in the first cycle after reset deassertion.
- Latency: a last beat accepted at edge t produces `out_valid=1` after edge t+2.
- Throughput: one beat per cycle while `out_ready=1`.
- The output holds stable while `out_valid && !out_ready`. `in_ready` is 0 throughout such a stall, and S1 holds.
- An output accepted in the same cycle a new last beat reaches S2: the new result is loaded the following edge, with no bubble.
- Asynchronous reset mid-frame discards all partial sums. No output is produced for the interrupted frames.

## Configuration
- `XRAD_CMAC_CONJ_EN` defined: adds input port `in_conj` (1 bit, registered into S1 with the beat).
  - When high, the beat uses the conjugate weight: `p_re = in_re*w_re + in_im*w_im`, `p_im = in_im*w_re - in_re*w_im`.
- Undefined: the port is absent and only the plain product is computed.

## Test plan
All scenarios use default parameters.
- **Single real beat.** `in_re=0x4000`, `in_im=0`, `w_re=0x4000`, `w_im=0`, `ch=0`, `last=1`. Expect `out_re=0x2000`, `out_im=0x0000`, `out_sat=0`, exactly 2 cycles after acceptance.
- **Imaginary product.** `in_im=0x4000`, `w_im=0x4000`, all other components 0, `last=1`. Expect `out_re=0xE000`, `out_im=0`.
- **Output saturation.** Four beats on ch 1 of `in_re=w_re=0x7FFF`, last on the 4th. Expect `out_re=0x7FFF`, `out_sat=1`. Then one further beat `0x4000*0x4000`, last, yields `0x2000` with `out_sat=0`, proving the clear.
- **Interleaving.** Alternate ch0/ch1, three beats each of `0x4000*0x4000`, last on the third of each. Expect ch0 then ch1 results, both `0x6000`.
- **Backpressure.** Hold `out_ready=0` for 5 cycles after `out_valid`. Outputs are held stable, `in_ready=0`, and no beat is lost. After release, the pending results appear in order.
- **Clear and reset.** Pulse `acc_clr`, and separately assert `rst_n` low, mid-frame. The next one-beat frame on that channel returns the single-product value only, and all outputs read 0 during reset.
